// File: rtl/sprite_restore.sv
// Restores a rectangular sprite area by copying background pixels from a selected
// map memory back to the screen, one pixel per cycle, with a fixed-latency read pipeline.
module sprite_restore #(
    parameter int SPR_W     = 2,
    parameter int SPR_H     = 2,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BASE_ADDR = 19200,
    parameter int ADDR_W    = 16,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOR_W   = 9,
    parameter int COLOR_LSB = 8,
    parameter int NUM_MAPS  = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [X_W-1:0]           iX,
    input  logic [Y_W-1:0]           iY,
    input  logic [1:0]               screen_sel,
    input  logic [32*NUM_MAPS-1:0]   map_q,
    output logic [ADDR_W-1:0]        address,
    output logic [X_W-1:0]           oX,
    output logic [Y_W-1:0]           oY,
    output logic [COLOR_W-1:0]       oColour,
    output logic                     plot,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       BASE32  = 32'(BASE_ADDR);
    localparam logic [31:0]       SCR_W32 = 32'(SCREEN_W);
    localparam logic [31:0]       SCR_H32 = 32'(SCREEN_H);
    localparam logic [3:0]        LAST_I  = 4'(SPR_W - 1);
    localparam logic [3:0]        LAST_J  = 4'(SPR_H - 1);
    localparam logic [2:0]        LAST_D  = 3'(RD_LAT - 1);

    state_t             state;
    logic [X_W-1:0]     x_r;
    logic [Y_W-1:0]     y_r;
    logic [1:0]         sel_r;
    logic [3:0]         i_cnt;
    logic [3:0]         j_cnt;
    logic [2:0]         d_cnt;

    // Read-latency pipeline: one stage per memory cycle, carrying the pixel position.
    logic [RD_LAT-1:0]  pv;
    logic [X_W-1:0]     px [RD_LAT];
    logic [Y_W-1:0]     py [RD_LAT];

    logic [X_W:0]       xi;
    logic [Y_W:0]       yj;
    logic               clipped;
    logic               issue;
    logic [31:0]        full_addr;
    logic [31:0]        word;
    logic               unused_bits;

    // One extra bit so x+i / y+j never wrap before the clip test.
    assign xi        = {1'b0, x_r} + (X_W+1)'(i_cnt);
    assign yj        = {1'b0, y_r} + (Y_W+1)'(j_cnt);
    assign clipped   = (32'(xi) >= SCR_W32) || (32'(yj) >= SCR_H32);
    assign issue     = (state == SCAN) && !clipped;
    assign full_addr = BASE32 + SCR_W32 * 32'(yj) + 32'(xi);
    assign address   = issue ? full_addr[ADDR_W-1:0] : BASE_A;

    // NOTE: default assignment first so every path drives word and no latch is inferred.
    always_comb begin
        word = map_q[31:0];
        for (int m = 1; m < NUM_MAPS; m++) begin
            if (32'(sel_r) == 32'(m)) word = map_q[32*m +: 32];
        end
    end

    assign plot    = pv[RD_LAT-1];
    assign oX      = plot ? px[RD_LAT-1] : '0;
    assign oY      = plot ? py[RD_LAT-1] : '0;
    assign oColour = plot ? word[COLOR_LSB +: COLOR_W] : '0;
    assign busy    = (state == SCAN) || (state == DRAIN);
    assign done    = (state == DONE);

    assign unused_bits = ^{word, full_addr};

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            x_r   <= '0;
            y_r   <= '0;
            sel_r <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            d_cnt <= '0;
            // NOTE: the pipeline is reset too, so an aborted run cannot leak a plot afterwards.
            pv    <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                px[s] <= '0;
                py[s] <= '0;
            end
        end else begin
            pv[0] <= issue;
            px[0] <= xi[X_W-1:0];
            py[0] <= yj[Y_W-1:0];
            for (int s = 1; s < RD_LAT; s++) begin
                pv[s] <= pv[s-1];
                px[s] <= px[s-1];
                py[s] <= py[s-1];
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        x_r   <= iX;
                        y_r   <= iY;
                        sel_r <= screen_sel;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (i_cnt == LAST_I) begin
                        i_cnt <= '0;
                        if (j_cnt == LAST_J) begin
                            d_cnt <= '0;
                            state <= DRAIN;
                        end else begin
                            j_cnt <= j_cnt + 4'd1;
                        end
                    end else begin
                        i_cnt <= i_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (d_cnt == LAST_D) state <= DONE;
                    else                 d_cnt <= d_cnt + 3'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_restore.sv
// Directed bench for sprite_restore: a default-size instance and a 4x3, two-cycle-latency
// instance, each fed by a behavioural map memory; plots are checked against a scoreboard.
module tb_sprite_restore;

    localparam int BASE = 19200;

    typedef struct {
        int due;
        int x;
        int y;
        int col;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  ix = '0;
    logic [6:0]  iy = '0;
    logic [1:0]  sel = '0;
    logic [95:0] mq1 = '0;
    logic [95:0] mq2 = '0;
    logic [15:0] a2_d = '0;

    logic [15:0] address1, address2;
    logic [7:0]  ox1, ox2;
    logic [6:0]  oy1, oy2;
    logic [8:0]  oc1, oc2;
    logic        plot1, plot2, busy1, busy2, done1, done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // Background word: colour field [16:8] differs between maps for the same address.
    function automatic logic [31:0] mem_word(input int m, input int a);
        logic [8:0] col;
        col = 9'((a * 7 + m * 101) & 511);
        return {8'(m + 1), 7'(a & 127), col, 8'((a & 255) ^ 90)};
    endfunction

    // Map memories: latency 1 for the first instance, latency 2 for the second.
    always @(posedge clock) begin
        for (int m = 0; m < 3; m++) begin
            mq1[32*m +: 32] <= mem_word(m, int'(address1));
            mq2[32*m +: 32] <= mem_word(m, int'(a2_d));
        end
        a2_d <= address2;
    end

    sprite_restore dut1 (
        .clock(clock), .reset(reset), .start(start1), .iX(ix), .iY(iy),
        .screen_sel(sel), .map_q(mq1), .address(address1), .oX(ox1), .oY(oy1),
        .oColour(oc1), .plot(plot1), .busy(busy1), .done(done1)
    );

    sprite_restore #(.SPR_W(4), .SPR_H(3), .RD_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .iX(ix), .iY(iy),
        .screen_sel(sel), .map_q(mq2), .address(address2), .oX(ox2), .oY(oy2),
        .oColour(oc2), .plot(plot2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic grab(input bit d2, output logic [31:0] a, output logic [31:0] x,
                        output logic [31:0] y, output logic [31:0] c,
                        output logic p, output logic b, output logic d);
        if (d2) begin
            a = 32'(address2); x = 32'(ox2); y = 32'(oy2); c = 32'(oc2);
            p = plot2; b = busy2; d = done2;
        end else begin
            a = 32'(address1); x = 32'(ox1); y = 32'(oy1); c = 32'(oc1);
            p = plot1; b = busy1; d = done1;
        end
    endtask

    task automatic check_reset_vals(input bit d2, input string tag);
        logic [31:0] a, x, y, c;
        logic p, b, d;
        grab(d2, a, x, y, c, p, b, d);
        check({tag, " address"}, a, 32'(BASE));
        check({tag, " oX"}, x, 32'd0);
        check({tag, " oY"}, y, 32'd0);
        check({tag, " oColour"}, c, 32'd0);
        check({tag, " plot"}, 32'(p), 32'd0);
        check({tag, " busy"}, 32'(b), 32'd0);
        check({tag, " done"}, 32'(d), 32'd0);
    endtask

    // One sprite run: checks address, busy, done and the plot stream every cycle.
    // abort_at>0 asserts reset right after that many plots; poke re-pulses start mid-run and in DONE.
    task automatic run(input bit d2, input int xx, input int yy, input logic [1:0] s,
                       input int abort_at, input bit poke);
        int w, h, lat, n, plots, sel_e, i, j, xi, yj, ea;
        bit clip;
        exp_t q[$];
        exp_t e;
        logic [31:0] a, x, y, c, w32;
        logic p, b, d;

        w = d2 ? 4 : 2;
        h = d2 ? 3 : 2;
        lat = d2 ? 2 : 1;
        n = w * h;
        sel_e = (s >= 2'd3) ? 0 : int'(s);
        plots = 0;

        ix = 8'(xx);
        iy = 7'(yy);
        sel = s;
        if (d2) start2 = 1'b1;
        else    start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        ix = ~ix;
        iy = ~iy;
        sel = ~sel;

        for (int k = 0; k <= n + lat + 2; k++) begin
            grab(d2, a, x, y, c, p, b, d);
            if (k < n) begin
                i = k % w;
                j = k / w;
                xi = xx + i;
                yj = yy + j;
                clip = (xi >= 160) || (yj >= 120);
                ea = clip ? BASE : ((BASE + 160 * yj + xi) & 65535);
                check($sformatf("addr[%0d]", k), a, 32'(ea));
                if (!clip) begin
                    w32 = mem_word(sel_e, ea);
                    e.due = k + lat;
                    e.x = xi;
                    e.y = yj;
                    e.col = int'(w32[16:8]);
                    q.push_back(e);
                end
            end else begin
                check($sformatf("addr idle[%0d]", k), a, 32'(BASE));
            end
            check($sformatf("busy[%0d]", k), 32'(b), 32'(k < n + lat));
            check($sformatf("done[%0d]", k), 32'(d), 32'(k == n + lat));

            if (q.size() > 0 && q[0].due == k) begin
                e = q.pop_front();
                plots++;
                check($sformatf("plot[%0d]", k), 32'(p), 32'd1);
                check($sformatf("oX[%0d]", k), x, 32'(e.x));
                check($sformatf("oY[%0d]", k), y, 32'(e.y));
                check($sformatf("oColour[%0d]", k), c, 32'(e.col));
            end else begin
                check($sformatf("noplot[%0d]", k), 32'(p), 32'd0);
                check($sformatf("oX zero[%0d]", k), x, 32'd0);
                check($sformatf("oColour zero[%0d]", k), c, 32'd0);
            end

            if (abort_at > 0 && plots == abort_at) begin
                reset = 1'b1;
                #1;
                check_reset_vals(d2, "abort");
                @(posedge clock);
                #1;
                reset = 1'b0;
                for (int t = 0; t < 6; t++) begin
                    grab(d2, a, x, y, c, p, b, d);
                    check($sformatf("post-abort plot[%0d]", t), 32'(p), 32'd0);
                    check($sformatf("post-abort done[%0d]", t), 32'(d), 32'd0);
                    check($sformatf("post-abort busy[%0d]", t), 32'(b), 32'd0);
                    tick();
                end
                q.delete();
                return;
            end

            if (poke) begin
                if (d2) start2 = (k == 1 || k == n + lat);
                else    start1 = (k == 1 || k == n + lat);
            end
            tick();
        end
        check("scoreboard empty", 32'(q.size()), 32'd0);
        check("plot count", 32'(plots), 32'(plots));
    endtask

    initial begin
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals(1'b0, "reset1");
        check_reset_vals(1'b1, "reset2");
        tick();
        tick();
        reset = 1'b0;
        tick();

        run(1'b0, 10, 5, 2'd0, 0, 1'b0);      // basic 2x2 run
        run(1'b0, 159, 119, 2'd0, 0, 1'b0);   // corner: one visible pixel
        run(1'b0, 20, 30, 2'd0, 0, 1'b1);     // start re-pulsed in SCAN and DONE
        run(1'b0, 40, 50, 2'd2, 2, 1'b0);     // reset after second plot
        run(1'b0, 10, 5, 2'd1, 0, 1'b0);      // map 1
        run(1'b0, 10, 5, 2'd3, 0, 1'b0);      // out-of-range select -> map 0
        run(1'b0, 200, 100, 2'd0, 0, 1'b0);   // fully clipped
        run(1'b1, 10, 5, 2'd0, 0, 1'b0);      // 4x3, latency 2
        run(1'b1, 157, 118, 2'd2, 0, 1'b0);   // 4x3 partially clipped

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
